l2_data_array_ctrl: RTL and testbench



---
 rtl/l2_pkg.sv | 37 +++
 rtl/l2_rr_arb2.sv | 39 +++
 rtl/l2_data_array_ctrl.sv | 159 +++++++++++++++
 tb/tb_l2_data_array_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// ============================================================================
//  Module   : l2_pkg
//  Purpose  : Shared constants, FSM state type and request record for the
//             L2 data-array sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_pkg;

  localparam int L2_DATA_WIDTH = 256;
  localparam int L2_ADDR_WIDTH = 4;
  localparam int L2_NUM_WMASKS = L2_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_CMD  = 3'd2,
    ST_CAPT = 3'd3,
    ST_RESP = 3'd4
  } l2_darray_state_t;

  typedef struct packed {
    logic                     we;
    logic [L2_ADDR_WIDTH-1:0] addr;
    logic [L2_NUM_WMASKS-1:0] wmask;
    logic [L2_DATA_WIDTH-1:0] wdata;
  } l2_darray_req_t;

  // One-hot vector for a two-requester index.
  function automatic logic [1:0] l2_onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/l2_rr_arb2.sv
// ============================================================================
//  Module   : l2_rr_arb2
//  Purpose  : Two-input round-robin arbiter. When both inputs request, the
//             pointer decides; after every taken grant the pointer moves to
//             the other requester.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic rr_ptr;

  // Grant: contested -> pointer wins, otherwise the lone requester.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = rr_ptr ? 2'b10 : 2'b01;
    end
  end

  // Pointer moves away from whoever was just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      rr_ptr <= ~gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_data_array_ctrl.sv
// ============================================================================
//  Module   : l2_data_array_ctrl
//  Purpose  : Sequencer + two-way arbiter in front of the single-port L2
//             data-array SRAM macro. One request in flight; macro pins are
//             driven from registers; read data is captured one cycle after
//             the command cycle and returned on the owner's resp_valid bit.
//  Options  : L2_DATA_ZERO_INIT_EN - zero every word after reset before the
//             array is opened to requesters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_data_array_ctrl
  import l2_pkg::*;
#(
  parameter int DATA_WIDTH = L2_DATA_WIDTH,
  parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
  parameter int NUM_WMASKS = L2_NUM_WMASKS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*NUM_WMASKS-1:0] req_wmask,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    init_done,
  output logic                    sram_csb0,
  output logic                    sram_web0,
  output logic [NUM_WMASKS-1:0]   sram_wmask0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  input  logic [DATA_WIDTH-1:0]   sram_dout0
);

`ifdef L2_DATA_ZERO_INIT_EN
  localparam l2_darray_state_t RESET_STATE = ST_INIT;
`else
  localparam l2_darray_state_t RESET_STATE = ST_IDLE;
`endif

  l2_darray_state_t state;
  l2_darray_req_t   req_q;
  logic             owner;
  logic             csb_q;
  logic             web_q;
  logic [1:0]       gnt;
  logic             grant_idx;
  logic             accept;

  // A grant is only offered while idle and out of reset.
  assign accept    = (state == ST_IDLE) && (req_valid != 2'b00) && !rst;
  assign req_ready = accept ? gnt : 2'b00;
  assign grant_idx = gnt[1];

  l2_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

`ifdef L2_DATA_ZERO_INIT_EN
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  init_done_q;
  logic                  init_active;

  // The zeroing sweep owns the macro pins; held off while rst is high.
  assign init_active = (state == ST_INIT) && !rst;
  assign sram_csb0   = init_active ? 1'b0 : csb_q;
  assign sram_web0   = init_active ? 1'b0 : web_q;
  assign sram_wmask0 = init_active ? '1   : req_q.wmask;
  assign sram_addr0  = init_active ? init_cnt : req_q.addr;
  assign sram_din0   = init_active ? '0   : req_q.wdata;
  assign init_done   = init_done_q;
`else
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = req_q.wmask;
  assign sram_addr0  = req_q.addr;
  assign sram_din0   = req_q.wdata;
  assign init_done   = 1'b1;
`endif

  // Main sequencer: grant capture, macro command, read capture, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RESET_STATE;
      req_q      <= '0;
      owner      <= 1'b0;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      resp_valid <= 2'b00;
      resp_rdata <= '0;
`ifdef L2_DATA_ZERO_INIT_EN
      init_cnt    <= '0;
      init_done_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_INIT: begin
`ifdef L2_DATA_ZERO_INIT_EN
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
            state       <= ST_IDLE;
            init_done_q <= 1'b1;
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_IDLE: begin
          if (accept) begin
            req_q.we    <= req_we[grant_idx];
            req_q.addr  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            req_q.wmask <= req_wmask[grant_idx*NUM_WMASKS +: NUM_WMASKS];
            req_q.wdata <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            owner       <= grant_idx;
            csb_q       <= 1'b0;
            web_q       <= ~req_we[grant_idx];
            state       <= ST_CMD;
          end
        end
        ST_CMD: begin
          // Macro latches at the end of this cycle; deselect right after.
          csb_q <= 1'b1;
          web_q <= 1'b1;
          if (req_q.we) begin
            resp_valid <= l2_onehot2(owner);
            resp_rdata <= '0;
            state      <= ST_RESP;
          end else begin
            state <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          resp_rdata <= sram_dout0;
          resp_valid <= l2_onehot2(owner);
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready[owner]) begin
            resp_valid <= 2'b00;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_l2_data_array_ctrl.sv
// ============================================================================
//  Module   : tb_l2_data_array_ctrl
//  Purpose  : Self-checking bench for l2_data_array_ctrl with a behavioural
//             SRAM macro and a transaction-level memory reference.
//  Options  : L2_DATA_ZERO_INIT_EN - expects the post-reset zeroing sweep.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_l2_data_array_ctrl;

  localparam int DW    = 256;
  localparam int AW    = 4;
  localparam int NM    = 32;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_we, resp_valid, resp_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*NM-1:0] req_wmask;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   resp_rdata, sram_din0, sram_dout0;
  logic            init_done, sram_csb0, sram_web0;
  logic [NM-1:0]   sram_wmask0;
  logic [AW-1:0]   sram_addr0;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem  [DEPTH];
  logic [DW-1:0] sram_mem [DEPTH];
  logic          exp_ptr;

  always #5 clk = ~clk;

  l2_data_array_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wmask   (req_wmask),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .init_done   (init_done),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  // Behavioural single-port macro: byte-masked write or registered read.
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < NM; b++)
          if (sram_wmask0[b]) sram_mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [DW-1:0] rep8(input logic [7:0] b);
    return {NM{b}};
  endfunction

  // Transaction-level write into the reference memory.
  task automatic ref_write(input logic [AW-1:0] a, input logic [NM-1:0] m, input logic [DW-1:0] d);
    logic [DW-1:0] mb;
    for (int b = 0; b < NM; b++) mb[b*8 +: 8] = {8{m[b]}};
    ref_mem[a] = (ref_mem[a] & ~mb) | (d & mb);
  endtask

  // One complete transaction on requester r, optional response backpressure.
  task automatic do_txn(input int r, input logic we, input logic [AW-1:0] a,
                        input logic [NM-1:0] m, input logic [DW-1:0] d, input int hold);
    int            n;
    int            csb_lows;
    int            o;
    logic [1:0]    oh;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] held;
    o  = 1 - r;
    oh = (r == 1) ? 2'b10 : 2'b01;
    exp_data = we ? '0 : ref_mem[a];
    req_we[r] = we;
    req_addr[r*AW +: AW]  = a;
    req_wmask[r*NM +: NM] = m;
    req_wdata[r*DW +: DW] = d;
    req_valid[r] = 1'b1;
    n = 0;
    #1;
    while (req_ready !== oh && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept", req_ready, oh);
    exp_ptr = (r == 0);
    if (we) ref_write(a, m, d);
    @(negedge clk);
    req_valid[r] = 1'b0;
    chk("web_cmd", sram_web0, !we);
    n = 1; csb_lows = 0;
    while (resp_valid === 2'b00 && n < 10) begin
      if (sram_csb0 === 1'b0) csb_lows++;
      @(negedge clk); n++;
    end
    chk("latency", n, we ? 2 : 3);
    chk("csb_lows", csb_lows, 1);
    chk("resp_bit", resp_valid, oh);
    chk("rdata", resp_rdata, exp_data);
    if (hold > 0) begin
      held = resp_rdata;
      req_we[o] = 1'b0;
      req_addr[o*AW +: AW]  = '0;
      req_wmask[o*NM +: NM] = '0;
      req_wdata[o*DW +: DW] = '0;
      req_valid[o] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", resp_valid, oh);
        chk("hold_rdata", resp_rdata, held);
        chk("hold_ready", req_ready, 2'b00);
        chk("hold_csb", sram_csb0, 1'b1);
      end
    end
    resp_ready[r] = 1'b1;
    @(negedge clk);
    resp_ready[r] = 1'b0;
    chk("resp_drop", resp_valid, 2'b00);
  endtask

  // Deassert rst and wait until the array is open again.
  task automatic release_reset();
`ifdef L2_DATA_ZERO_INIT_EN
    req_we[0] = 1'b0;
    req_addr[AW-1:0] = '0;
    req_valid = 2'b01;
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("init_done", init_done, (i == 16));
      if (i < 16) chk("init_ready", req_ready, 2'b00);
      chk("init_resp", resp_valid, 2'b00);
    end
    req_valid = 2'b00;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
`else
    req_valid = 2'b00;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("init_done", init_done, 1'b1);
      chk("post_rst_resp", resp_valid, 2'b00);
    end
`endif
    exp_ptr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] got;
    logic       gi;

    rst = 1'b1;
    req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wmask = '0; req_wdata = '0;
    resp_ready = 2'b00;
    exp_ptr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_resp", resp_valid, 2'b00);
    chk("rst_csb", sram_csb0, 1'b1);
    chk("rst_web", sram_web0, 1'b1);
    chk("rst_addr", sram_addr0, '0);
    chk("rst_wmask", sram_wmask0, '0);
    chk("rst_din", sram_din0, '0);
    chk("rst_rdata", resp_rdata, '0);
    release_reset();

    // Establish known contents (zeroed array when the sweep is built in).
    for (int a = 0; a < DEPTH; a++) begin
`ifdef L2_DATA_ZERO_INIT_EN
      do_txn(a % 2, 1'b0, a[AW-1:0], '0, '0, 0);
`else
      do_txn(a % 2, 1'b1, a[AW-1:0], '1, rand_line(), 0);
`endif
    end

    // Full write then read-back.
    do_txn(0, 1'b1, 4'd3, '1, rep8(8'hA5), 0);
    do_txn(0, 1'b0, 4'd3, '0, '0, 0);
    // Partial write, then a zero-mask write that must change nothing.
    do_txn(0, 1'b1, 4'd5, '1, rep8(8'h11), 0);
    do_txn(1, 1'b1, 4'd5, 32'h0000_0001, rep8(8'hFF), 0);
    do_txn(1, 1'b1, 4'd5, '0, rand_line(), 0);
    do_txn(0, 1'b0, 4'd5, '0, '0, 0);
    // Backpressured read on requester 1 with requester 0 waiting.
    do_txn(1, 1'b0, 4'd3, '0, '0, 10);
    do_txn(0, 1'b0, 4'd0, '0, '0, 0);

    // Reset during the capture cycle of a read.
    req_we[0] = 1'b0; req_addr[AW-1:0] = 4'd5; req_valid[0] = 1'b1;
    n = 0; #1;
    while (req_ready !== 2'b01 && n < 20) begin @(negedge clk); #1; n++; end
    chk("capt_accept", req_ready, 2'b01);
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("capt_rst_resp", resp_valid, 2'b00);
    chk("capt_rst_csb", sram_csb0, 1'b1);
    release_reset();

    // Both requesters continuously valid: alternating grants from pointer 0.
    req_we = 2'b00;
    req_addr[0 +: AW]  = 4'd5;
    req_addr[AW +: AW] = 4'd3;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      n = 0; #1;
      while (req_ready === 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
      got = req_ready;
      chk("arb_grant", got, exp_ptr ? 2'b10 : 2'b01);
      gi = (got == 2'b10);
      exp_ptr = ~gi;
      @(negedge clk);
      n = 0;
      while (resp_valid === 2'b00 && n < 10) begin @(negedge clk); n++; end
      chk("arb_resp_bit", resp_valid, got);
      chk("arb_rdata", resp_rdata, ref_mem[gi ? 4'd3 : 4'd5]);
      resp_ready = got;
      if (g == 3) req_valid = 2'b00;
      @(negedge clk);
      resp_ready = 2'b00;
    end

    // Randomised traffic against the reference memory.
    for (int t = 0; t < 40; t++) begin
      int            r;
      int            hold;
      int            sel;
      logic          we;
      logic [AW-1:0] a;
      logic [NM-1:0] m;
      r    = $urandom_range(0, 1);
      we   = 1'($urandom_range(0, 1));
      a    = AW'($urandom_range(0, DEPTH-1));
      sel  = $urandom_range(0, 3);
      case (sel)
        0:       m = '1;
        1:       m = '0;
        default: m = $urandom;
      endcase
      hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_txn(r, we, a, m, rand_line(), hold);
      if (hold > 0) do_txn(1 - r, 1'b0, '0, '0, '0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
